// File: rtl/conv_pe_scheduler_if.sv
// Handshake bundle between the layer controller / OFM writer and conv_pe_scheduler.
// The stall_cycles member exists only when SCHED_STALL_CNT_EN is defined.
interface conv_pe_scheduler_if #(
  parameter int unsigned NUM_PE = 16,
  parameter int unsigned ADDR_W = 20
);
  logic              start;
  logic              abort;
  logic [NUM_PE-1:0] pe_mask;
  logic              ofm_ready;
  logic [NUM_PE-1:0] PE_en;
  logic [NUM_PE-1:0] PE_finish;
  logic [ADDR_W-1:0] ifm_base;
  logic [7:0]        pix_row;
  logic [7:0]        pix_col;
  logic              busy;
  logic              done;
`ifdef SCHED_STALL_CNT_EN
  logic [31:0]       stall_cycles;

  modport master (
    input  start, abort, pe_mask, ofm_ready,
    output PE_en, PE_finish, ifm_base, pix_row, pix_col, busy, done, stall_cycles
  );
  modport slave (
    output start, abort, pe_mask, ofm_ready,
    input  PE_en, PE_finish, ifm_base, pix_row, pix_col, busy, done, stall_cycles
  );
`else
  modport master (
    input  start, abort, pe_mask, ofm_ready,
    output PE_en, PE_finish, ifm_base, pix_row, pix_col, busy, done
  );
  modport slave (
    output start, abort, pe_mask, ofm_ready,
    input  PE_en, PE_finish, ifm_base, pix_row, pix_col, busy, done
  );
`endif
endinterface

// File: rtl/conv_pe_scheduler.sv
// Walks the output feature map pixel by pixel, strobing the PE array and waiting on the OFM writer.
// Optional feature: define SCHED_STALL_CNT_EN to add the saturating stall_cycles counter.
module conv_pe_scheduler #(
  parameter int unsigned NUM_PE     = 16,
  parameter int unsigned OFM_W      = 56,
  parameter int unsigned OFM_H      = 56,
  parameter int unsigned IFM_W      = 58,
  parameter int unsigned CH_WORDS   = 4,
  parameter int unsigned RUN_CYCLES = 33,
  parameter int unsigned ADDR_W     = 20
) (
  input logic                 clk,
  input logic                 reset,
  conv_pe_scheduler_if.master bus
);

  localparam int unsigned CntW = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam logic [CntW-1:0] RunLast = CntW'(RUN_CYCLES - 1);
  localparam logic [7:0] LastCol = 8'(OFM_W - 1);
  localparam logic [7:0] LastRow = 8'(OFM_H - 1);

  typedef logic [ADDR_W+7:0] prod_t;

  typedef enum logic [2:0] {StIdle, StEn, StRun, StFin, StWait, StDone} state_e;

  state_e            state_q;
  logic [NUM_PE-1:0] mask_q;
  logic [NUM_PE-1:0] en_q;
  logic [NUM_PE-1:0] fin_q;
  logic [ADDR_W-1:0] base_q;
  logic [7:0]        row_q;
  logic [7:0]        col_q;
  logic [CntW-1:0]   run_cnt_q;
  logic              busy_q;
  logic              done_q;
`ifdef SCHED_STALL_CNT_EN
  logic [31:0]       stall_q;
`endif

  // Wide product, then truncated to the address width.
  function automatic logic [ADDR_W-1:0] base_of(input logic [7:0] r, input logic [7:0] c);
    prod_t p;
    p = (prod_t'(r) * prod_t'(IFM_W) + prod_t'(c)) * prod_t'(CH_WORDS);
    return p[ADDR_W-1:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      mask_q    <= '0;
      en_q      <= '0;
      fin_q     <= '0;
      base_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      run_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SCHED_STALL_CNT_EN
      stall_q   <= '0;
`endif
    end else begin
      // Strobes are single-cycle unless a transition below re-asserts them.
      en_q   <= '0;
      fin_q  <= '0;
      done_q <= 1'b0;
      if (bus.abort && (state_q != StIdle)) begin
        state_q <= StIdle;
        row_q   <= '0;
        col_q   <= '0;
        base_q  <= '0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.start && !bus.abort) begin
              mask_q    <= bus.pe_mask;
              en_q      <= bus.pe_mask;
              row_q     <= '0;
              col_q     <= '0;
              run_cnt_q <= '0;
              base_q    <= '0;
              busy_q    <= 1'b1;
              state_q   <= StEn;
`ifdef SCHED_STALL_CNT_EN
              stall_q   <= '0;
`endif
            end
          end
          StEn: begin
            run_cnt_q <= '0;
            state_q   <= StRun;
          end
          StRun: begin
            if (run_cnt_q == RunLast) begin
              fin_q   <= mask_q;
              state_q <= StFin;
            end else begin
              run_cnt_q <= run_cnt_q + CntW'(1);
            end
          end
          StFin: state_q <= StWait;
          StWait: begin
            if (bus.ofm_ready) begin
              if ((row_q == LastRow) && (col_q == LastCol)) begin
                done_q  <= 1'b1;
                state_q <= StDone;
              end else if (col_q == LastCol) begin
                col_q   <= '0;
                row_q   <= row_q + 8'd1;
                base_q  <= base_of(row_q + 8'd1, 8'd0);
                en_q    <= mask_q;
                state_q <= StEn;
              end else begin
                col_q   <= col_q + 8'd1;
                base_q  <= base_of(row_q, col_q + 8'd1);
                en_q    <= mask_q;
                state_q <= StEn;
              end
            end
`ifdef SCHED_STALL_CNT_EN
            else if (stall_q != '1) begin
              stall_q <= stall_q + 32'd1;
            end
`endif
          end
          StDone: begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.PE_en     = en_q;
  assign bus.PE_finish = fin_q;
  assign bus.ifm_base  = base_q;
  assign bus.pix_row   = row_q;
  assign bus.pix_col   = col_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
`ifdef SCHED_STALL_CNT_EN
  assign bus.stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_conv_pe_scheduler.sv
// Bench for conv_pe_scheduler: timing table and directed corner cases on a default instance,
// plus a randomized full-layer walk on a short-RUN instance checked against a pixel-level model.
module tb_conv_pe_scheduler;

  localparam int unsigned NP  = 16;
  localparam int unsigned AW  = 20;
  localparam int unsigned OW  = 56;
  localparam int unsigned OH  = 56;
  localparam int unsigned IW  = 58;
  localparam int unsigned CW  = 4;
  localparam int unsigned RC  = 33;
  localparam int unsigned FRC = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_pe_scheduler_if #(.NUM_PE(NP), .ADDR_W(AW)) bus ();
  conv_pe_scheduler_if #(.NUM_PE(NP), .ADDR_W(AW)) fbus ();

  conv_pe_scheduler #(
    .NUM_PE(NP), .OFM_W(OW), .OFM_H(OH), .IFM_W(IW), .CH_WORDS(CW), .RUN_CYCLES(RC), .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  conv_pe_scheduler #(
    .NUM_PE(NP), .OFM_W(OW), .OFM_H(OH), .IFM_W(IW), .CH_WORDS(CW), .RUN_CYCLES(FRC), .ADDR_W(AW)
  ) dut_fast (
    .clk(clk),
    .reset(reset),
    .bus(fbus)
  );

  typedef struct {
    int          cyc;
    logic        start;
    logic [15:0] mask;
    logic [15:0] en;
    logic [15:0] fin;
    logic        busy;
    logic [19:0] base;
    logic [7:0]  col;
  } vec_t;

  localparam int NV = 11;
  vec_t vec[NV];

  int checks = 0;
  int errors = 0;
  int t = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic step();
    @(negedge clk);
    t++;
  endtask

  function automatic int exp_base(input int r, input int c);
    return ((r * IW + c) * CW) % (1 << AW);
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_en"},   32'(bus.PE_en), 0);
    check({tag, "_fin"},  32'(bus.PE_finish), 0);
    check({tag, "_base"}, 32'(bus.ifm_base), 0);
    check({tag, "_row"},  32'(bus.pix_row), 0);
    check({tag, "_col"},  32'(bus.pix_col), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
  endtask

  int          vi;
  int          spurious;
  int          c;
  int          k;
  int          en_cyc;
  int          done_cyc;
  int          done_cnt;
  logic [31:0] stall_exp;
  logic [15:0] fmask;
  logic        rdy;

  initial begin
    vec[0]  = '{0,   1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 20'd0,  8'd0};
    vec[1]  = '{1,   1'b0, 16'h00F0, 16'hFFFF, 16'h0000, 1'b1, 20'd0,  8'd0};
    vec[2]  = '{2,   1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 20'd0,  8'd0};
    vec[3]  = '{34,  1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 20'd0,  8'd0};
    vec[4]  = '{35,  1'b0, 16'h1234, 16'h0000, 16'hFFFF, 1'b1, 20'd0,  8'd0};
    vec[5]  = '{36,  1'b0, 16'h1234, 16'h0000, 16'h0000, 1'b1, 20'd0,  8'd0};
    vec[6]  = '{37,  1'b0, 16'h1234, 16'hFFFF, 16'h0000, 1'b1, 20'd4,  8'd1};
    vec[7]  = '{71,  1'b0, 16'h1234, 16'h0000, 16'hFFFF, 1'b1, 20'd4,  8'd1};
    vec[8]  = '{73,  1'b0, 16'h1234, 16'hFFFF, 16'h0000, 1'b1, 20'd8,  8'd2};
    vec[9]  = '{74,  1'b1, 16'h1234, 16'h0000, 16'h0000, 1'b1, 20'd8,  8'd2};
    vec[10] = '{109, 1'b0, 16'h1234, 16'hFFFF, 16'h0000, 1'b1, 20'd12, 8'd3};

    reset = 1'b1;
    bus.start = 1'b0;  bus.abort = 1'b0;  bus.pe_mask = '0;  bus.ofm_ready = 1'b0;
    fbus.start = 1'b0; fbus.abort = 1'b0; fbus.pe_mask = '0; fbus.ofm_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    check("reset_fast_busy", 32'(fbus.busy), 0);
    check("reset_fast_en", 32'(fbus.PE_en), 0);
    reset = 1'b0;
    @(negedge clk);
    t = 0;

    // Timing table: one layer, mask FFFF latched, ofm_ready high, pe_mask wiggled afterwards.
    vi = 0;
    while (t <= 109) begin
      bus.start = 1'b0;
      bus.ofm_ready = 1'b1;
      bus.pe_mask = 16'h1234;
      if (vi < NV && vec[vi].cyc == t) begin
        check($sformatf("vec%0d_en", vi),   32'(bus.PE_en),     32'(vec[vi].en));
        check($sformatf("vec%0d_fin", vi),  32'(bus.PE_finish), 32'(vec[vi].fin));
        check($sformatf("vec%0d_busy", vi), 32'(bus.busy),      32'(vec[vi].busy));
        check($sformatf("vec%0d_base", vi), 32'(bus.ifm_base),  32'(vec[vi].base));
        check($sformatf("vec%0d_col", vi),  32'(bus.pix_col),   32'(vec[vi].col));
        bus.start = vec[vi].start;
        bus.pe_mask = vec[vi].mask;
        vi++;
      end
      step();
    end

    // Backpressure: 7 low cycles in the WAIT of pixel 5 stretch its period to 43.
    while (t < 230) begin
      bus.ofm_ready = !(t >= 216 && t <= 222);
      if (t == 181) begin
        check("bp_px5_en", 32'(bus.PE_en), 32'hFFFF);
        check("bp_px5_base", 32'(bus.ifm_base), 20);
      end
      if (t == 217) check("bp_no_early_en", 32'(bus.PE_en), 0);
      if (t == 224) begin
        check("bp_px6_en", 32'(bus.PE_en), 32'hFFFF);
        check("bp_px6_col", 32'(bus.pix_col), 6);
        check("bp_px6_base", 32'(bus.ifm_base), 24);
`ifdef SCHED_STALL_CNT_EN
        check("bp_stall_cycles", bus.stall_cycles, 7);
`endif
      end
      step();
    end

    // Abort in the WAIT of pixel 100 (row 1, col 44).
    spurious = 0;
    while (t <= 3700) begin
      bus.ofm_ready = (t != 3643);
      bus.abort = (t == 3643);
      if (t == 3643) begin
        check("ab_row", 32'(bus.pix_row), 1);
        check("ab_col", 32'(bus.pix_col), 44);
        check("ab_base", 32'(bus.ifm_base), 408);
        check("ab_busy", 32'(bus.busy), 1);
      end
      if (t == 3644) check_idle("ab_after");
      if (t > 3644 && (bus.done || bus.PE_en != 0 || bus.busy)) spurious++;
      step();
    end
    check("ab_quiet", spurious, 0);

    // Reset in the middle of RUN of pixel 0, then a clean restart.
    bus.start = 1'b1;
    bus.pe_mask = 16'hFFFF;
    step();
    bus.start = 1'b0;
    while (t < 3712) step();
    check("rst_busy_before", 32'(bus.busy), 1);
    reset = 1'b1;
    #1;
    check_idle("rst_async");
    step();
    reset = 1'b0;
    step();
    bus.start = 1'b1;
    bus.pe_mask = 16'hA5A5;
    step();
    bus.start = 1'b0;
    check("rst_restart_en", 32'(bus.PE_en), 32'hA5A5);
    check("rst_restart_base", 32'(bus.ifm_base), 0);
    check("rst_restart_row", 32'(bus.pix_row), 0);
    check("rst_restart_col", 32'(bus.pix_col), 0);
    check("rst_restart_busy", 32'(bus.busy), 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("rst_abort_busy", 32'(bus.busy), 0);

    // Randomized full layer on the short-RUN instance against a pixel-level schedule model.
    fmask = 16'h00F0;
    c = 0; k = 0; en_cyc = 1; done_cyc = -1; done_cnt = 0; stall_exp = 0;
    fbus.pe_mask = fmask;
    fbus.start = 1'b1;
    fbus.ofm_ready = 1'b1;
    step();
    c = 1;
    while (!(done_cyc >= 0 && c > done_cyc + 1) && c < 30000) begin
      check("f_en", 32'(fbus.PE_en), (done_cyc < 0 && c == en_cyc) ? 32'(fmask) : 0);
      check("f_fin", 32'(fbus.PE_finish),
            (done_cyc < 0 && c == en_cyc + 1 + int'(FRC)) ? 32'(fmask) : 0);
      check("f_done", 32'(fbus.done), (c == done_cyc) ? 1 : 0);
      check("f_busy", 32'(fbus.busy), (done_cyc < 0 || c <= done_cyc) ? 1 : 0);
      if (fbus.done) done_cnt++;
      if (done_cyc < 0 && c == en_cyc) begin
        check("f_row", 32'(fbus.pix_row), k / OW);
        check("f_col", 32'(fbus.pix_col), k % OW);
        check("f_base", 32'(fbus.ifm_base), exp_base(k / OW, k % OW));
        if (k == 55)   check("f_base_0_55", 32'(fbus.ifm_base), 220);
        if (k == 56)   check("f_base_1_0", 32'(fbus.ifm_base), 232);
        if (k == 3135) check("f_base_55_55", 32'(fbus.ifm_base), 12980);
      end
      if (c == done_cyc) begin
        check("f_hold_row", 32'(fbus.pix_row), 55);
        check("f_hold_col", 32'(fbus.pix_col), 55);
        check("f_hold_base", 32'(fbus.ifm_base), 12980);
      end
      fbus.pe_mask = 16'($urandom);
      if (c == done_cyc) fbus.start = 1'b1;
      else fbus.start = (done_cyc < 0) && ($urandom_range(0, 49) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      fbus.ofm_ready = rdy;
      if (done_cyc < 0 && c >= en_cyc + 2 + int'(FRC)) begin
        if (rdy) begin
          if (k == int'(OW * OH) - 1) done_cyc = c + 1;
          else begin
            k++;
            en_cyc = c + 1;
          end
        end else if (stall_exp != 32'hFFFF_FFFF) begin
          stall_exp++;
        end
      end
      step();
      c++;
    end
    fbus.start = 1'b0;
    check("f_done_reached", (done_cyc >= 0) ? 1 : 0, 1);
    check("f_done_count", done_cnt, 1);
    check("f_idle_after", 32'(fbus.busy), 0);
`ifdef SCHED_STALL_CNT_EN
    check("f_stall_cycles", fbus.stall_cycles, stall_exp);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_pe_scheduler.md
# conv_pe_scheduler

Sequencer that drives the 16-PE convolution sub-top through a full output feature map without a host toggling PE strobes by hand. Per output pixel it issues the IFM window base address, a one-cycle `PE_en` strobe, waits a fixed MAC window, and then issues a one-cycle `PE_finish` strobe. Before moving to the next pixel it waits for the OFM writer's `ofm_ready`. It sits between the layer-level `cal_start` source and the `Sub_top_CONV` PE array.

## Interface
- `NUM_PE`, 16: number of PEs; width of the strobe buses.
- `OFM_W`, 56: output columns.
- `OFM_H`, 56: output rows.
- `IFM_W`, 58: padded IFM row width in pixels.
- `CH_WORDS`, 4: 32-bit IFM words per pixel (16 channels x 8 bit / 32).
- `RUN_CYCLES`, 33: cycles between the `PE_en` cycle and the `PE_finish` cycle.
- `ADDR_W`, 20: IFM address width.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  layer start pulse; sampled only in IDLE.
- `abort`  in  1  forces IDLE; has priority over everything except reset.
- `pe_mask`  in  NUM_PE  PEs enabled for this layer; latched on an accepted start.
- `ofm_ready`  in  1  OFM writer has consumed the current pixel.
- `PE_en`  out  NUM_PE  one-cycle start strobe per pixel (= latched mask).
- `PE_finish`  out  NUM_PE  one-cycle finish strobe per pixel (= latched mask).
- `ifm_base`  out  ADDR_W  word address of the current window's top-left pixel.
- `pix_row`, `pix_col`  out  8 each  current output coordinate.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last pixel completes.

## Operation
- States: IDLE, EN, RUN, FIN, WAIT, DONE. All outputs are registered.
- IDLE:
  - On `start`=1 and `abort`=0, latch `pe_mask` and clear row/col and `run_cnt`, then go to EN.
  - `start` is ignored in every other state.
- EN: `PE_en`=mask for exactly one cycle, then RUN.
- RUN:
  - `run_cnt` counts 0..RUN_CYCLES-1.
  - At RUN_CYCLES-1, go to FIN. RUN_CYCLES=0 is illegal.
- FIN: `PE_finish`=mask for one cycle, then WAIT.
- WAIT: hold until `ofm_ready`=1, then:
  - If last pixel (row=OFM_H-1, col=OFM_W-1), go to DONE.
  - Else if col=OFM_W-1: col=0, row+1, go to EN.
  - Else: col+1, go to EN.
- DONE: `done`=1 for one cycle, then IDLE. Row/col hold their final values.
- `ifm_base` = (row*IFM_W + col)*CH_WORDS.
  - Computed from the next row/col and registered on entry to EN, so it is stable from the `PE_en` cycle through the end of WAIT.
  - The intermediate product is ADDR_W+8 bits wide and truncated to ADDR_W bits.
- `abort` in any non-IDLE state:
  - Next state is IDLE; strobes return to 0 and `done` does not pulse.
  - Row/col/`ifm_base` clear to 0.
- `ofm_ready` is ignored outside WAIT.
- A `pe_mask` of 0 is legal. The sequence runs with all-zero strobes.

## Timing
- Reset: state=IDLE and every output is 0 (`PE_en`, `PE_finish`, `ifm_base`, `pix_row`, `pix_col`, `busy`, `done`).
- `start` sampled at edge N: `PE_en` high in cycle N+1; `busy` high from N+1.
- `PE_finish` is high in cycle N+2+RUN_CYCLES, which is 34 cycles after `PE_en` with defaults.
- With `ofm_ready` held high, the pixel period is RUN_CYCLES+3 = 36 cycles.
- Each extra low cycle of `ofm_ready` adds exactly one cycle.
- Full default layer with `ofm_ready`=1:
  - 3136 x 36 = 112896 cycles from the first `PE_en` to the `done` cycle inclusive, minus 1.
  - `done` falls one cycle after WAIT of the last pixel.
  - `busy` falls in the cycle after `done`.
- `start` in the same cycle as DONE→IDLE is not accepted. It is accepted only in a cycle where the state is already IDLE.

## Configuration
- `SCHED_STALL_CNT_EN`
  - Defined: adds output `stall_cycles` (32 bit). It counts cycles spent in WAIT with `ofm_ready`=0, clears on an accepted `start` and on reset, and saturates at all-ones.
  - Undefined: the port and the counter do not exist, and the rest of the behaviour is identical.

## Test plan
- Reset mid-RUN (assert `reset` at cycle 10 of pixel 0): all outputs 0 immediately, state IDLE; a fresh `start` restarts at row 0, col 0, `ifm_base`=0.
- `start` with `pe_mask`=16'hFFFF, `ofm_ready`=1: `PE_en`=FFFF one cycle after start, `PE_finish`=FFFF 34 cycles later, next `PE_en` 36 cycles after the first.
- Address walk: pixel (0,55) → `ifm_base`=220; pixel (1,0) → 232; last pixel (55,55) → 12980; `done` pulses once after pixel 3136.
- Backpressure: hold `ofm_ready`=0 for 7 cycles in WAIT of pixel 5 → period stretches to 43 cycles; `stall_cycles`=7 when the macro is defined.
- `abort` during WAIT of pixel 100 → IDLE next cycle, no `done`, strobes 0; `start` pulsed mid-layer (pixel 2) → ignored, sequence unchanged.
- `pe_mask`=16'h00F0: strobes equal 00F0 for the whole layer even if `pe_mask` changes to FFFF after start.
